mem_arbiter_2x1: RTL and testbench

Two-requester, one-port memory arbiter that lets the instruction-fetch path and the load/store path of a multi-cycle TinyRV1 processor share a single memory port. It accepts val/rdy requests from both requesters, grants one per transaction with round-robin priority, and forwards the request to memory. It holds a single outstanding transaction and routes the memory response back to the requester that issued it. It sits between the processor datapath's `imemreq`/`dmemreq` signals and a unified memory.

---
 rtl/mem_arbiter_2x1.sv | 132 +++++++++++++
 tb/tb_mem_arbiter_2x1.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2x1.sv
// Two-requester round-robin arbiter in front of a single memory port.
// It keeps one transaction outstanding and sends each response back to the port that issued it.
module mem_arbiter_2x1 #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_val,
  output logic               req0_rdy,
  input  logic               req0_type,
  input  logic [p_nbits-1:0] req0_addr,
  input  logic [p_nbits-1:0] req0_wdata,
  output logic               resp0_val,
  output logic [p_nbits-1:0] resp0_data,

  input  logic               req1_val,
  output logic               req1_rdy,
  input  logic               req1_type,
  input  logic [p_nbits-1:0] req1_addr,
  input  logic [p_nbits-1:0] req1_wdata,
  output logic               resp1_val,
  output logic [p_nbits-1:0] resp1_data,

  output logic               memreq_val,
  input  logic               memreq_rdy,
  output logic               memreq_type,
  output logic [p_nbits-1:0] memreq_addr,
  output logic [p_nbits-1:0] memreq_wdata,
  input  logic               memresp_val,
  input  logic [p_nbits-1:0] memresp_data,

  output logic               err_stray
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_r, state_next_s;
  logic   owner_r, owner_next_s;
  logic   prio_r, prio_next_s;
  logic   err_stray_r, err_stray_next_s;
  logic   gnt_s;

  // Arbitration, handshakes, response routing and next-state logic
  always_comb begin
    state_next_s     = state_r;
    owner_next_s     = owner_r;
    prio_next_s      = prio_r;
    err_stray_next_s = err_stray_r;
    gnt_s            = prio_r;
    memreq_val       = 1'b0;
    req0_rdy         = 1'b0;
    req1_rdy         = 1'b0;
    resp0_val        = 1'b0;
    resp1_val        = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_val & ~req1_val) begin
          gnt_s = 1'b0;
        end else if (req1_val & ~req0_val) begin
          gnt_s = 1'b1;
        end else begin
          gnt_s = prio_r;
        end
        memreq_val = req0_val | req1_val;
        req0_rdy   = memreq_rdy & ~gnt_s;
        req1_rdy   = memreq_rdy & gnt_s;
        if (memreq_val & memreq_rdy) begin
          state_next_s = BUSY;
          owner_next_s = gnt_s;
          prio_next_s  = ~gnt_s;
        end else begin
          state_next_s = IDLE;
        end
        // A response with nothing outstanding is latched as an error
        if (memresp_val) begin
          err_stray_next_s = 1'b1;
        end else begin
          err_stray_next_s = err_stray_r;
        end
      end
      BUSY: begin
        if (memresp_val) begin
          resp0_val    = ~owner_r;
          resp1_val    = owner_r;
          state_next_s = IDLE;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Request field mux: port 0 fields whenever port 1 is not the active grant
  always_comb begin
    if ((req0_val | req1_val) & gnt_s) begin
      memreq_type  = req1_type;
      memreq_addr  = req1_addr;
      memreq_wdata = req1_wdata;
    end else begin
      memreq_type  = req0_type;
      memreq_addr  = req0_addr;
      memreq_wdata = req0_wdata;
    end
  end

  assign resp0_data = memresp_data;
  assign resp1_data = memresp_data;
  assign err_stray  = err_stray_r;

  // State, owner, priority and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      prio_r      <= 1'b0;
      err_stray_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      owner_r     <= owner_next_s;
      prio_r      <= prio_next_s;
      err_stray_r <= err_stray_next_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Directed and randomized bench for mem_arbiter_2x1.
// A queue-based reference model of outstanding transactions checks all outputs every cycle.
module tb_mem_arbiter_2x1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_val, req0_rdy, req0_type, resp0_val;
  logic [31:0] req0_addr, req0_wdata, resp0_data;
  logic        req1_val, req1_rdy, req1_type, resp1_val;
  logic [31:0] req1_addr, req1_wdata, resp1_data;
  logic        memreq_val, memreq_rdy, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;
  logic        err_stray;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ports awaiting a response, the port that wins a tie, sticky error
  int q_owner[$];
  int tie_port = 0;
  bit m_stray  = 1'b0;
  bit known    = 1'b0;

  mem_arbiter_2x1 #(.p_nbits(32)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .resp0_val(resp0_val), .resp0_data(resp0_data),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp1_val(resp1_val), .resp1_data(resp1_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    if (req0_val && !req1_val) return 0;
    if (req1_val && !req0_val) return 1;
    return tie_port;
  endfunction

  task automatic check_all();
    bit busy;
    bit any;
    int g;
    busy = (q_owner.size() != 0);
    any  = req0_val || req1_val;
    g    = winner();
    chk("resp0_data", resp0_data, memresp_data);
    chk("resp1_data", resp1_data, memresp_data);
    chk("err_stray", {31'd0, err_stray}, {31'd0, m_stray});
    if (busy) begin
      chk("memreq_val_busy", {31'd0, memreq_val}, 32'd0);
      chk("req0_rdy_busy", {31'd0, req0_rdy}, 32'd0);
      chk("req1_rdy_busy", {31'd0, req1_rdy}, 32'd0);
      chk("resp0_val_busy", {31'd0, resp0_val}, {31'd0, memresp_val && q_owner[0] == 0});
      chk("resp1_val_busy", {31'd0, resp1_val}, {31'd0, memresp_val && q_owner[0] == 1});
    end else begin
      chk("memreq_val", {31'd0, memreq_val}, {31'd0, any});
      chk("req0_rdy", {31'd0, req0_rdy}, {31'd0, memreq_rdy && g == 0});
      chk("req1_rdy", {31'd0, req1_rdy}, {31'd0, memreq_rdy && g == 1});
      chk("resp0_val_idle", {31'd0, resp0_val}, 32'd0);
      chk("resp1_val_idle", {31'd0, resp1_val}, 32'd0);
      chk("memreq_type", {31'd0, memreq_type}, {31'd0, (any && g == 1) ? req1_type : req0_type});
      chk("memreq_addr", memreq_addr, (any && g == 1) ? req1_addr : req0_addr);
      chk("memreq_wdata", memreq_wdata, (any && g == 1) ? req1_wdata : req0_wdata);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge
  task automatic tick();
    bit busy;
    int g;
    @(negedge clk);
    if (known) check_all();
    busy = (q_owner.size() != 0);
    g    = winner();
    if (rst) begin
      q_owner.delete();
      tie_port = 0;
      m_stray  = 1'b0;
      known    = 1'b1;
    end else if (busy) begin
      if (memresp_val) void'(q_owner.pop_front());
    end else begin
      if (memresp_val) m_stray = 1'b1;
      if ((req0_val || req1_val) && memreq_rdy) begin
        q_owner.push_back(g);
        tie_port = 1 - g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_val = 1'b0; req0_type = 1'b0; req0_addr = 32'd0; req0_wdata = 32'd0;
    req1_val = 1'b0; req1_type = 1'b0; req1_addr = 32'd0; req1_wdata = 32'd0;
    memreq_rdy = 1'b1; memresp_val = 1'b0; memresp_data = 32'd0;

    // Reset for two cycles, then a single read from port 0
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_memreq_val", {31'd0, memreq_val}, 32'd0);
    chk("rst_req0_rdy", {31'd0, req0_rdy}, 32'd1);
    chk("rst_req1_rdy", {31'd0, req1_rdy}, 32'd0);
    chk("rst_err_stray", {31'd0, err_stray}, 32'd0);
    req0_val = 1'b1; req0_addr = 32'h200;
    #1;
    chk("read_addr", memreq_addr, 32'h200);
    chk("read_rdy0", {31'd0, req0_rdy}, 32'd1);
    tick();
    req0_val = 1'b0; memresp_val = 1'b1; memresp_data = 32'hDEADBEEF;
    #1;
    chk("read_resp0_val", {31'd0, resp0_val}, 32'd1);
    chk("read_resp0_data", resp0_data, 32'hDEADBEEF);
    chk("read_resp1_val", {31'd0, resp1_val}, 32'd0);
    tick();
    memresp_val = 1'b0;

    // Contention from a fresh reset: grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_val = 1'b1; req0_addr = 32'h100;
    req1_val = 1'b1; req1_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_addr", memreq_addr, (i % 2 == 0) ? 32'h100 : 32'h2000);
      tick();
      memresp_val = 1'b1; memresp_data = 32'h1000 + i;
      #1;
      chk("rr_resp_owner", {30'd0, resp1_val, resp0_val}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      memresp_val = 1'b0;
    end
    req0_val = 1'b0; req1_val = 1'b0;

    // Backpressure on a port 1 write
    req1_val = 1'b1; req1_type = 1'b1; req1_wdata = 32'h55; memreq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req1_rdy", {31'd0, req1_rdy}, 32'd0);
      tick();
    end
    memreq_rdy = 1'b1;
    #1;
    chk("bp_type", {31'd0, memreq_type}, 32'd1);
    chk("bp_wdata", memreq_wdata, 32'h55);
    tick();

    // Long latency with port 0 waiting
    req1_val = 1'b0; req1_type = 1'b0;
    req0_val = 1'b1; req0_addr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ll_req0_rdy", {31'd0, req0_rdy}, 32'd0);
      chk("ll_memreq_val", {31'd0, memreq_val}, 32'd0);
      tick();
    end
    memresp_val = 1'b1;
    tick();
    memresp_val = 1'b0;
    #1;
    chk("ll_req0_fire", {31'd0, req0_rdy}, 32'd1);
    tick();
    req0_val = 1'b0; memresp_val = 1'b1;
    tick();
    memresp_val = 1'b0;

    // Stray response in IDLE
    memresp_val = 1'b1;
    #1;
    chk("stray_resp_vals", {30'd0, resp1_val, resp0_val}, 32'd0);
    tick();
    memresp_val = 1'b0;
    #1;
    chk("stray_set", {31'd0, err_stray}, 32'd1);
    tick();
    tick();
    chk("stray_sticky", {31'd0, err_stray}, 32'd1);

    // Reset while BUSY, late response, then immediate port 1 fire
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_val = 1'b1;
    tick();
    req0_val = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    req1_val = 1'b1;
    #1;
    chk("midrst_req1_rdy", {31'd0, req1_rdy}, 32'd1);
    chk("midrst_stray_clr", {31'd0, err_stray}, 32'd0);
    tick();
    req1_val = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; memresp_val = 1'b1;
    tick();
    memresp_val = 1'b0;
    #1;
    chk("late_resp_stray", {31'd0, err_stray}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      req0_val     = ($urandom_range(0, 99) < 60);
      req1_val     = ($urandom_range(0, 99) < 60);
      req0_type    = 1'($urandom_range(0, 1));
      req1_type    = 1'($urandom_range(0, 1));
      req0_addr    = $urandom;
      req1_addr    = $urandom;
      req0_wdata   = $urandom;
      req1_wdata   = $urandom;
      memreq_rdy   = ($urandom_range(0, 99) < 70);
      memresp_data = $urandom;
      if (q_owner.size() != 0) memresp_val = ($urandom_range(0, 99) < 40);
      else                     memresp_val = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
